// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers x/y/de from hsync/vsync and checks line/frame timing.
// Optional: define VGA_MON_ERR_COUNT_EN to enable the saturating err_count output.
module vga_sync_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_POL    = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       frame_start,
    output logic       lock,
    output logic       line_err,
    output logic       frame_err,
    output logic [7:0] err_count
);
    localparam logic [9:0] H_TOTAL_C = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [9:0] H_END_C   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_END_C   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_SYNC_C  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C  = 10'(V_SYNC);
    localparam logic [9:0] H_FIRST   = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_LAST    = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_FIRST   = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_LAST    = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX   = 10'd1023;
    localparam logic [3:0] LOCK_C    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [3:0] good_cnt_q, good_cnt_d, good_inc;
    logic       frame_bad_q, frame_bad_d, exempt_q, exempt_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       de_q, de_d, fs_q, fs_d, lock_q, lock_d;
    logic       line_err_q, line_err_d, frame_err_q, frame_err_d;
    logic       hs_act, vs_act, h_lead, h_trail, v_lead, v_trail;
    logic       checking, l_err, f_err, any_err, in_active;

    // Normalise syncs so that 1 always means "sync asserted".
    assign hs_act  = (SYNC_POL != 0) ? hsync : ~hsync;
    assign vs_act  = (SYNC_POL != 0) ? vsync : ~vsync;
    assign h_lead  = hs_act & ~hs_prev_q;
    assign h_trail = ~hs_act & hs_prev_q;
    assign v_lead  = vs_act & ~vs_prev_q;
    assign v_trail = ~vs_act & vs_prev_q;
    assign good_inc = good_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        hs_prev_d   = hs_prev_q;
        vs_prev_d   = vs_prev_q;
        good_cnt_d  = good_cnt_q;
        frame_bad_d = frame_bad_q;
        exempt_d    = exempt_q;
        x_d         = x_q;
        y_d         = y_q;
        de_d        = de_q;
        lock_d      = lock_q;
        fs_d        = 1'b0;
        line_err_d  = 1'b0;
        frame_err_d = 1'b0;
        checking    = 1'b0;
        l_err       = 1'b0;
        f_err       = 1'b0;
        any_err     = 1'b0;
        in_active   = 1'b0;
        if (pix_en) begin
            hs_prev_d = hs_act;
            vs_prev_d = vs_act;
            if (h_lead)
                hcnt_d = '0;
            else if (hcnt_q != CNT_MAX)
                hcnt_d = hcnt_q + 10'd1;
            if (v_lead)
                vcnt_d = '0;
            else if (h_lead && vcnt_q != CNT_MAX)
                vcnt_d = vcnt_q + 10'd1;

            // The first line after leaving SEARCH is not trusted, so it is not checked.
            checking = (state_q != SEARCH) && !exempt_q;
            l_err = checking && ((h_lead && hcnt_q != H_END_C) ||
                                 (h_trail && hcnt_d != H_SYNC_C) ||
                                 (hcnt_d == H_TOTAL_C));
            f_err = checking && ((v_lead && vcnt_q != V_END_C) ||
                                 (v_trail && vcnt_d != V_SYNC_C));
            any_err     = l_err | f_err;
            line_err_d  = l_err;
            frame_err_d = f_err;
            fs_d        = v_lead;
            if (h_lead)
                exempt_d = 1'b0;

            case (state_q)
                SEARCH: begin
                    if (v_lead) begin
                        state_d     = ACQUIRE;
                        good_cnt_d  = '0;
                        frame_bad_d = 1'b0;
                        exempt_d    = 1'b1;
                    end
                end
                ACQUIRE: begin
                    if (v_lead) begin
                        frame_bad_d = 1'b0;
                        if (any_err || frame_bad_q) begin
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_inc;
                            if (good_inc >= LOCK_C) begin
                                state_d = LOCKED;
                                lock_d  = 1'b1;
                            end
                        end
                    end else if (any_err) begin
                        good_cnt_d  = '0;
                        frame_bad_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state_d = SEARCH;
                        lock_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    lock_d  = 1'b0;
                end
            endcase

            in_active = (hcnt_d >= H_FIRST) && (hcnt_d <= H_LAST) &&
                        (vcnt_d >= V_FIRST) && (vcnt_d <= V_LAST);
            x_d  = in_active ? (hcnt_d - H_FIRST) : '0;
            y_d  = in_active ? (vcnt_d - V_FIRST) : '0;
            de_d = in_active && lock_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            good_cnt_q  <= '0;
            frame_bad_q <= 1'b0;
            exempt_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            lock_q      <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            hs_prev_q   <= hs_prev_d;
            vs_prev_q   <= vs_prev_d;
            good_cnt_q  <= good_cnt_d;
            frame_bad_q <= frame_bad_d;
            exempt_q    <= exempt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            de_q        <= de_d;
            fs_q        <= fs_d;
            lock_q      <= lock_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign lock        = lock_q;
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;

`ifdef VGA_MON_ERR_COUNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Simultaneous line and frame errors form a single event.
    always_comb begin
        err_count_d = err_count_q;
        if (any_err && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count_q <= '0;
        else
            err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a reduced timing (15x8 pixel frames).
module tb_vga_sync_monitor;
    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int H_TOTAL  = 15;
`ifdef VGA_MON_ERR_COUNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, pix_en, hsync, vsync;
    logic [9:0] x, y;
    logic       de, frame_start, lock, line_err, frame_err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int gap = 1;
    int de_cnt, le_cnt, fe_cnt, fs_cnt, err_locked_cnt;
    bit seen_first;
    logic [9:0] first_x, first_y, last_x, last_y;

    always #5 clk = ~clk;

    vga_sync_monitor #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(0), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .de(de), .frame_start(frame_start), .lock(lock),
        .line_err(line_err), .frame_err(frame_err), .err_count(err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        de_cnt = 0; le_cnt = 0; fe_cnt = 0; fs_cnt = 0; err_locked_cnt = 0;
        seen_first = 1'b0;
    endtask

    // Pulses are tallied every clock; de only on clocks following a sample.
    task automatic mon(input bit sampled);
        if (sampled && de) begin
            de_cnt++;
            if (!seen_first) begin
                first_x = x; first_y = y; seen_first = 1'b1;
            end
            last_x = x; last_y = y;
        end
        le_cnt += int'(line_err);
        fe_cnt += int'(frame_err);
        fs_cnt += int'(frame_start);
        if ((line_err || frame_err) && lock) err_locked_cnt++;
    endtask

    task automatic px(input bit hs_a, input bit vs_a);
        @(negedge clk);
        hsync = ~hs_a; vsync = ~vs_a; pix_en = 1'b1;
        @(posedge clk); #1; mon(1'b1);
        if (gap != 0) begin
            @(negedge clk); pix_en = 1'b0;
            @(posedge clk); #1; mon(1'b0);
        end
    endtask

    task automatic send_line(input int len, input int hsw, input bit vs_a);
        for (int p = 0; p < len; p++) px(p < hsw, vs_a);
    endtask

    task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                              input int bad_hsw);
        for (int l = 0; l < nlines; l++) begin
            if (l == bad_line) send_line(bad_len, bad_hsw, l < V_SYNC);
            else               send_line(H_TOTAL, H_SYNC, l < V_SYNC);
        end
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_de", de, 0);
        chk("rst_lock", lock, 0);
        chk("rst_pulses", {frame_start, line_err, frame_err}, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(posedge clk);

        // Clean stream with pix_en every second clock: lock at vsync edge #3.
        send_frame(8, -1, 0, 0);
        send_frame(8, -1, 0, 0);
        chk("acq_lock_low", lock, 0);
        chk("acq_frame_starts", fs_cnt, 2);
        chk("acq_no_line_err", le_cnt, 0);
        chk("acq_no_frame_err", fe_cnt, 0);
        clr();
        send_frame(8, -1, 0, 0);
        $display("frame 3: lock=%0d de_samples=%0d", lock, de_cnt);
        chk("lock_after_edge3", lock, 1);
        chk("de_samples", de_cnt, H_ACTIVE * V_ACTIVE);
        chk("first_x", first_x, 0);
        chk("first_y", first_y, 0);
        chk("last_x", last_x, H_ACTIVE - 1);
        chk("last_y", last_y, V_ACTIVE - 1);
        chk("clean_line_err", le_cnt, 0);
        chk("clean_frame_starts", fs_cnt, 1);

        // Long line while locked, then relock over three vsync edges.
        gap = 0;
        clr();
        send_frame(8, 3, H_TOTAL + 1, H_SYNC);
        $display("long line: line_err=%0d lock=%0d", le_cnt, lock);
        chk("long_line_err", le_cnt, 1);
        chk("long_lock_same_clk", err_locked_cnt, 0);
        chk("long_lock_drop", lock, 0);
        chk("long_no_frame_err", fe_cnt, 0);
        clr();
        send_frame(8, -1, 0, 0);
        send_frame(8, -1, 0, 0);
        chk("relock_not_yet", lock, 0);
        clr();
        send_frame(8, -1, 0, 0);
        chk("relock", lock, 1);
        chk("relock_de", de_cnt, H_ACTIVE * V_ACTIVE);

        // Short hsync pulse while locked.
        clr();
        send_frame(8, 2, H_TOTAL, H_SYNC - 1);
        $display("short hsync: line_err=%0d lock=%0d", le_cnt, lock);
        chk("hsw_line_err", le_cnt, 1);
        chk("hsw_lock_same_clk", err_locked_cnt, 0);
        chk("hsw_lock_drop", lock, 0);
        send_frame(8, -1, 0, 0);
        send_frame(8, -1, 0, 0);
        send_frame(8, -1, 0, 0);
        chk("relock2", lock, 1);

        // Frame one line short while locked.
        clr();
        send_frame(7, -1, 0, 0);
        chk("short_frame_pending", fe_cnt, 0);
        chk("short_frame_still_locked", lock, 1);
        send_frame(8, -1, 0, 0);
        $display("short frame: frame_err=%0d lock=%0d", fe_cnt, lock);
        chk("short_frame_err", fe_cnt, 1);
        chk("short_frame_no_line_err", le_cnt, 0);
        chk("short_frame_lock_same_clk", err_locked_cnt, 0);
        chk("short_frame_lock_drop", lock, 0);
        chk("err_count_3", err_count, ERR_EN ? 3 : 0);

        // 300 bad (short) lines while acquiring.
        clr();
        for (int l = 0; l < 302; l++) send_line(H_TOTAL - 1, H_SYNC, l < V_SYNC);
        $display("bad lines: line_err=%0d err_count=%0d", le_cnt, err_count);
        chk("bad_lines_line_err", le_cnt, 300);
        chk("bad_lines_lock", lock, 0);
        chk("err_count_sat", err_count, ERR_EN ? 255 : 0);

        // Reset in the middle of a frame.
        send_line(5, H_SYNC, 1'b1);
        @(negedge clk); reset = 1'b1; pix_en = 1'b0;
        @(posedge clk); #1;
        chk("midrst_outputs", {x, y, de, frame_start, lock, line_err, frame_err}, 0);
        chk("midrst_err_count", err_count, 0);
        @(negedge clk); reset = 1'b0;
        clr();
        send_frame(8, -1, 0, 0);
        send_frame(8, -1, 0, 0);
        send_frame(8, -1, 0, 0);
        chk("post_rst_lock", lock, 1);
        chk("post_rst_no_err", le_cnt + fe_cnt, 0);
        chk("post_rst_err_count", err_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
